tagged_sync_fifo: RTL and testbench

Parametrised single-clock FIFO for the m2s request/serve path. It is the successor of the current request FIFO. It adds correct full/empty at true DEPTH, non-power-of-two depth, occupancy and threshold flags, and sticky overflow/underflow errors. It also has an integrated tag generator that stamps each accepted write with a sequence ID (the "next id available" stream). It sits between the requester side and the multi2sim VPI step logic, one instance per direction.

---
 rtl/tagged_sync_fifo.sv | 147 ++++++++++++++
 tb/tb_tagged_sync_fifo.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/tagged_sync_fifo.sv
// rtl/tagged_sync_fifo.sv - single-clock FIFO that stamps each accepted write with a sequence tag
// Optional macro TAGGED_FIFO_FWFT_EN selects first-word-fall-through reads; default is a registered 1-cycle read.
module tagged_sync_fifo #(
  parameter int DATA_WIDTH    = 74,
  parameter int TAG_WIDTH     = 10,
  parameter int ADDR_WIDTH    = 8,
  parameter int DEPTH         = 256,
  parameter int AFULL_THRESH  = 252,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [TAG_WIDTH-1:0]  wr_tag,
  output logic [TAG_WIDTH-1:0]  next_tag,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [TAG_WIDTH-1:0]  tag_out,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam int EW = TAG_WIDTH + DATA_WIDTH;
  // Pointers only need enough bits to address DEPTH entries.
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);
  localparam logic [IW-1:0] LAST_C   = IW'(DEPTH - 1);

  if (DEPTH < 2 || DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
    $error("tagged_sync_fifo: DEPTH out of range 2..2**ADDR_WIDTH");
  end
  if (AFULL_THRESH < 0 || AFULL_THRESH > DEPTH) begin : g_bad_afull
    $error("tagged_sync_fifo: AFULL_THRESH out of range 0..DEPTH");
  end
  if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH) begin : g_bad_aempty
    $error("tagged_sync_fifo: AEMPTY_THRESH out of range 0..DEPTH");
  end

  logic [EW-1:0]        mem [DEPTH];
  logic [IW-1:0]        wr_ptr;
  logic [IW-1:0]        rd_ptr;
  logic [CW-1:0]        count_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic                 wr_acc;
  logic                 rd_acc;
  logic                 ovf_q;
  logic                 udf_q;
  logic [EW-1:0]        head;

  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AFULL_C);
  assign almost_empty = (count_q <= AEMPTY_C);
  assign count        = count_q;
  assign next_tag     = tag_q;
  assign wr_tag       = tag_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  // No write-through when full and no read bypass when empty.
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) begin
      mem[wr_ptr] <= {tag_q, data_in};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      tag_q   <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= (wr_ptr == LAST_C) ? '0 : wr_ptr + IW'(1);
        tag_q  <= tag_q + TAG_WIDTH'(1);
      end
      if (rd_acc) begin
        rd_ptr <= (rd_ptr == LAST_C) ? '0 : rd_ptr + IW'(1);
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Set has priority over clear so a same-cycle error is never lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (wr_en && full)    ovf_q <= 1'b1;
      else if (clr_err)     ovf_q <= 1'b0;
      if (rd_en && empty)   udf_q <= 1'b1;
      else if (clr_err)     udf_q <= 1'b0;
    end
  end

`ifdef TAGGED_FIFO_FWFT_EN
  // Head is shown combinationally; gated to zero so an empty FIFO never exposes stale storage.
  assign data_out = empty ? '0 : head[DATA_WIDTH-1:0];
  assign tag_out  = empty ? '0 : head[EW-1:DATA_WIDTH];
  assign rd_valid = !empty;
`else
  logic [DATA_WIDTH-1:0] dout_q;
  logic [TAG_WIDTH-1:0]  tout_q;
  logic                  rvalid_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_q   <= '0;
      tout_q   <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd_acc;
      if (rd_acc) begin
        dout_q <= head[DATA_WIDTH-1:0];
        tout_q <= head[EW-1:DATA_WIDTH];
      end
    end
  end

  assign data_out = dout_q;
  assign tag_out  = tout_q;
  assign rd_valid = rvalid_q;
`endif

endmodule

// File: tb/tb_tagged_sync_fifo.sv
// tb/tb_tagged_sync_fifo.sv - randomized bench for tagged_sync_fifo against a queue-based model
module tb_tagged_sync_fifo;

  localparam int DW = 8;
  localparam int TW = 3;
  localparam int AW = 3;
  localparam int DEPTH = 5;
  localparam int AF = 4;
  localparam int AE = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          rd_en = 1'b0;
  logic          clr_err = 1'b0;
  logic [TW-1:0] wr_tag, next_tag, tag_out;
  logic [DW-1:0] data_out;
  logic          full, almost_full, empty, almost_empty, rd_valid, overflow, underflow;
  logic [AW:0]   count;

  int total = 0;
  int bad = 0;

  tagged_sync_fifo #(
    .DATA_WIDTH(DW), .TAG_WIDTH(TW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
    .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in),
    .wr_tag(wr_tag), .next_tag(next_tag), .full(full), .almost_full(almost_full),
    .rd_en(rd_en), .data_out(data_out), .tag_out(tag_out), .rd_valid(rd_valid),
    .empty(empty), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          q[$];
  int            m_tag;
  logic          m_ovf, m_udf, m_rv;
  logic [DW-1:0] m_dout;
  logic [TW-1:0] m_tout;
  bit            model_ok = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: a plain queue of {tag,data}, sizes and flags from its length.
  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_tag = 0; m_ovf = 0; m_udf = 0; m_rv = 0; m_dout = '0; m_tout = '0;
      model_ok = 1;
    end else if (model_ok) begin
      bit was_full, was_empty;
      ent_t e;
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      m_rv = 0;
      if (rd_en && !was_empty) begin
        e = q.pop_front();
        m_dout = e.data; m_tout = e.tag; m_rv = 1;
      end
      if (wr_en && !was_full) begin
        e.tag = TW'(m_tag); e.data = data_in;
        q.push_back(e);
        m_tag = (m_tag + 1) % (1 << TW);
      end
      if (wr_en && was_full) m_ovf = 1; else if (clr_err) m_ovf = 0;
      if (rd_en && was_empty) m_udf = 1; else if (clr_err) m_udf = 0;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("count", 32'(count), 32'(q.size()));
      chk("full", 32'(full), 32'(q.size() == DEPTH));
      chk("empty", 32'(empty), 32'(q.size() == 0));
      chk("almost_full", 32'(almost_full), 32'(q.size() >= AF));
      chk("almost_empty", 32'(almost_empty), 32'(q.size() <= AE));
      chk("next_tag", 32'(next_tag), 32'(m_tag));
      chk("wr_tag", 32'(wr_tag), 32'(m_tag));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("underflow", 32'(underflow), 32'(m_udf));
`ifdef TAGGED_FIFO_FWFT_EN
      chk("rd_valid", 32'(rd_valid), 32'(q.size() != 0));
      chk("data_out", 32'(data_out), (q.size() != 0) ? 32'(q[0].data) : 32'd0);
      chk("tag_out", 32'(tag_out), (q.size() != 0) ? 32'(q[0].tag) : 32'd0);
`else
      chk("rd_valid", 32'(rd_valid), 32'(m_rv));
      chk("data_out", 32'(data_out), 32'(m_dout));
      chk("tag_out", 32'(tag_out), 32'(m_tout));
`endif
    end
  end

  task automatic step(input logic r, input logic w, input logic [DW-1:0] d,
                      input logic rd, input logic c);
    @(negedge clk); #2;
    rst_n = r; wr_en = w; data_in = d; rd_en = rd; clr_err = c;
    @(posedge clk); #1;
    rst_n = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
  endtask

  task automatic lit_wait();
    @(negedge clk); #1;
  endtask

  initial begin
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    lit_wait();
    chk("lit_reset_count", 32'(count), 0);
    chk("lit_reset_empty", 32'(empty), 1);
    chk("lit_reset_aempty", 32'(almost_empty), 1);

    for (int i = 0; i < 5; i++) begin
      lit_wait();
      chk("lit_fill_wr_tag", 32'(wr_tag), 32'(i));
      step(1, 1, DW'(8'h10 + i), 0, 0);
    end
    lit_wait();
    chk("lit_fill_count", 32'(count), 5);
    chk("lit_fill_full", 32'(full), 1);
    chk("lit_fill_next_tag", 32'(next_tag), 5);

    step(1, 1, 8'hEE, 0, 0);
    lit_wait();
    chk("lit_ovf", 32'(overflow), 1);
    chk("lit_ovf_count", 32'(count), 5);
    chk("lit_ovf_next_tag", 32'(next_tag), 5);

    for (int i = 0; i < 5; i++) begin
`ifdef TAGGED_FIFO_FWFT_EN
      lit_wait();
      chk("lit_drain_data", 32'(data_out), 32'(8'h10 + i));
      chk("lit_drain_tag", 32'(tag_out), 32'(i));
      chk("lit_drain_valid", 32'(rd_valid), 1);
      step(1, 0, 0, 1, 0);
`else
      step(1, 0, 0, 1, 0);
      lit_wait();
      chk("lit_drain_data", 32'(data_out), 32'(8'h10 + i));
      chk("lit_drain_tag", 32'(tag_out), 32'(i));
      chk("lit_drain_valid", 32'(rd_valid), 1);
`endif
    end
    lit_wait();
    chk("lit_drain_empty", 32'(empty), 1);
    chk("lit_drain_valid_low", 32'(rd_valid), 0);

    step(1, 0, 0, 1, 0);
    lit_wait();
    chk("lit_udf", 32'(underflow), 1);
`ifndef TAGGED_FIFO_FWFT_EN
    chk("lit_udf_hold", 32'(data_out), 32'h14);
`endif
    step(1, 0, 0, 0, 1);
    lit_wait();
    chk("lit_clr_ovf", 32'(overflow), 0);
    chk("lit_clr_udf", 32'(underflow), 0);

    for (int i = 0; i < 3; i++) step(1, 1, DW'(8'h20 + i), 0, 0);
    lit_wait();
    chk("lit_tag_wrap", 32'(next_tag), 0);
    chk("lit_pre_reset_count", 32'(count), 3);

    step(0, 0, 0, 0, 0);
    lit_wait();
    chk("lit_rst_count", 32'(count), 0);
    chk("lit_rst_empty", 32'(empty), 1);
    chk("lit_rst_valid", 32'(rd_valid), 0);
    chk("lit_rst_tag", 32'(next_tag), 0);

    step(1, 1, 8'h5A, 0, 0);
    lit_wait();
    chk("lit_first_count", 32'(count), 1);
`ifdef TAGGED_FIFO_FWFT_EN
    chk("lit_fwft_data", 32'(data_out), 32'h5A);
    chk("lit_fwft_valid", 32'(rd_valid), 1);
`endif

    for (int i = 0; i < 4; i++) step(1, 1, DW'(8'h30 + i), 0, 0);
    step(1, 1, 8'h77, 0, 1);
    lit_wait();
    chk("lit_set_wins", 32'(overflow), 1);
    step(1, 0, 0, 0, 1);
    lit_wait();
    chk("lit_clr_alone", 32'(overflow), 0);

    for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) step(1, 1, DW'(8'h40 + i), 1, 0);
    lit_wait();
    chk("lit_simul_count", 32'(count), 2);

    for (int p = 0; p < 15; p++) begin
      int pw, pr;
      pw = $urandom_range(10, 90);
      pr = $urandom_range(10, 90);
      for (int i = 0; i < 200; i++) begin
        step(($urandom_range(0, 199) != 0),
             ($urandom_range(0, 99) < pw),
             DW'($urandom),
             ($urandom_range(0, 99) < pr),
             ($urandom_range(0, 99) < 5));
      end
    end
    lit_wait();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
